// File: rtl/noc_intr_pkt_decoder_pkg.sv
// -----------------------------------------------------------------------------
// noc_intr_pkt_decoder_pkg
//  Shared NoC header field layout, interrupt payload field offsets and the
//  decoder FSM state type. Field positions follow the on-chip NoC header
//  format: DST_X[49:42], DST_Y[41:34], LENGTH[29:22], TYPE[21:14].
// -----------------------------------------------------------------------------
package noc_intr_pkt_decoder_pkg;

    localparam int unsigned NOC_DATA_WIDTH = 64;
    localparam int unsigned NOC_X_WIDTH    = 8;
    localparam int unsigned NOC_Y_WIDTH    = 8;

    localparam int unsigned MSG_DST_X_HI   = 49;
    localparam int unsigned MSG_DST_X_LO   = 42;
    localparam int unsigned MSG_DST_Y_HI   = 41;
    localparam int unsigned MSG_DST_Y_LO   = 34;
    localparam int unsigned MSG_LENGTH_HI  = 29;
    localparam int unsigned MSG_LENGTH_LO  = 22;
    localparam int unsigned MSG_TYPE_HI    = 21;
    localparam int unsigned MSG_TYPE_LO    = 14;

    localparam int unsigned MSG_LENGTH_WIDTH = MSG_LENGTH_HI - MSG_LENGTH_LO + 1;
    localparam int unsigned MSG_TYPE_WIDTH   = MSG_TYPE_HI - MSG_TYPE_LO + 1;

    localparam logic [MSG_TYPE_WIDTH-1:0] MSG_TYPE_INTERRUPT = 8'd33;

    // Interrupt payload flit fields
    localparam int unsigned INTR_VEC_LO  = 0;
    localparam int unsigned INTR_VEC_HI  = 5;
    localparam int unsigned INTR_TYPE_LO = 16;
    localparam int unsigned INTR_TYPE_HI = 17;

    typedef enum logic [1:0] {
        ST_HDR   = 2'd0,
        ST_PAY   = 2'd1,
        ST_DRAIN = 2'd2
    } dec_state_e;

endpackage

// File: rtl/intr_desc_fifo.sv
// -----------------------------------------------------------------------------
// intr_desc_fifo
//  Synchronous val/rdy FIFO holding decoded interrupt descriptors.
//  Ports:
//   clk, rst_n             clock, async active-low reset
//   in_val_i/in_rdy_o      push handshake (in_rdy_o = not full, registered)
//   in_data_i              pushed word
//   out_val_o/out_rdy_i    pop handshake (out_val_o = not empty)
//   out_data_o             head word
// -----------------------------------------------------------------------------
module intr_desc_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_val_i,
    output logic             in_rdy_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_val_o,
    input  logic             out_rdy_i,
    output logic [WIDTH-1:0] out_data_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push;
    logic             pop;

    // Readiness depends only on the registered count: a pop in the same
    // cycle never frees a slot for a push.
    assign in_rdy_o   = (count_q != CW'(DEPTH));
    assign out_val_o  = (count_q != '0);
    assign out_data_o = mem_q[rd_ptr_q];

    assign push = in_val_i && in_rdy_o;
    assign pop  = out_val_o && out_rdy_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= CW'(DEPTH));
`endif

endmodule

// File: rtl/noc_intr_pkt_decoder.sv
// -----------------------------------------------------------------------------
// noc_intr_pkt_decoder
//  Consumes the interrupt NoC flit stream. Interrupt packets addressed to
//  this tile have their first payload flit queued as a descriptor; every
//  other packet is drained by its header length and counted as a drop.
//  Ports:
//   clk, rst_n                         clock, async active-low reset
//   my_x, my_y                         this tile's coordinates
//   noc_in_val/noc_in_rdy/noc_in_data  incoming flit handshake
//   intr_val/intr_rdy                  descriptor handshake to core
//   intr_payload, intr_vec, intr_type  head descriptor and decoded fields
//   drop_cnt                           saturating discarded-packet count
// -----------------------------------------------------------------------------
module noc_intr_pkt_decoder
    import noc_intr_pkt_decoder_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DROP_CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NOC_X_WIDTH-1:0]    my_x,
    input  logic [NOC_Y_WIDTH-1:0]    my_y,
    input  logic                      noc_in_val,
    output logic                      noc_in_rdy,
    input  logic [NOC_DATA_WIDTH-1:0] noc_in_data,
    output logic                      intr_val,
    input  logic                      intr_rdy,
    output logic [63:0]               intr_payload,
    output logic [5:0]                intr_vec,
    output logic [1:0]                intr_type,
    output logic [DROP_CNT_W-1:0]     drop_cnt
);

    dec_state_e                  state_q, state_d;
    logic [MSG_LENGTH_WIDTH-1:0] rem_q, rem_d;
    logic                        first_q, first_d;
    logic [DROP_CNT_W-1:0]       drop_q, drop_d;

    logic                        accept;
    logic                        drop_inc;
    logic                        push;
    logic                        fifo_in_rdy;
    logic [63:0]                 fifo_head;

    logic [NOC_X_WIDTH-1:0]      hdr_x;
    logic [NOC_Y_WIDTH-1:0]      hdr_y;
    logic [MSG_LENGTH_WIDTH-1:0] hdr_len;
    logic [MSG_TYPE_WIDTH-1:0]   hdr_type;
    logic                        hdr_is_intr;
    logic                        hdr_match;

    assign hdr_x       = noc_in_data[MSG_DST_X_HI:MSG_DST_X_LO];
    assign hdr_y       = noc_in_data[MSG_DST_Y_HI:MSG_DST_Y_LO];
    assign hdr_len     = noc_in_data[MSG_LENGTH_HI:MSG_LENGTH_LO];
    assign hdr_type    = noc_in_data[MSG_TYPE_HI:MSG_TYPE_LO];
    assign hdr_is_intr = (hdr_type == MSG_TYPE_INTERRUPT);
    assign hdr_match   = hdr_is_intr && (hdr_x == my_x) && (hdr_y == my_y);

    // Only the flit that would be pushed can stall; fifo_in_rdy is derived
    // from the registered FIFO count, so intr_rdy never reaches noc_in_rdy.
    assign noc_in_rdy = !((state_q == ST_PAY) && first_q && !fifo_in_rdy);
    assign accept     = noc_in_val && noc_in_rdy;

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        first_d  = first_q;
        drop_inc = 1'b0;
        push     = 1'b0;
        case (state_q)
            ST_HDR: begin
                if (accept) begin
                    if (hdr_len == '0) begin
                        // Zero-length interrupt is malformed; other empty packets are ignored.
                        drop_inc = hdr_is_intr;
                    end else if (hdr_match) begin
                        state_d = ST_PAY;
                        rem_d   = hdr_len;
                        first_d = 1'b1;
                    end else begin
                        state_d  = ST_DRAIN;
                        rem_d    = hdr_len;
                        drop_inc = 1'b1;
                    end
                end
            end
            ST_PAY: begin
                if (accept) begin
                    push    = first_q;
                    first_d = 1'b0;
                    rem_d   = rem_q - 1'b1;
                    if (rem_q == 8'd1) begin
                        state_d = ST_HDR;
                    end
                end
            end
            ST_DRAIN: begin
                if (accept) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == 8'd1) begin
                        state_d = ST_HDR;
                    end
                end
            end
            default: state_d = ST_HDR;
        endcase

        drop_d = drop_q;
        if (drop_inc && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HDR;
            rem_q   <= '0;
            first_q <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            first_q <= first_d;
            drop_q  <= drop_d;
        end
    end

    intr_desc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_val_i   (push),
        .in_rdy_o   (fifo_in_rdy),
        .in_data_i  (noc_in_data),
        .out_val_o  (intr_val),
        .out_rdy_i  (intr_rdy),
        .out_data_o (fifo_head)
    );

    assign intr_payload = fifo_head;
    assign intr_vec     = fifo_head[INTR_VEC_HI:INTR_VEC_LO];
    assign intr_type    = fifo_head[INTR_TYPE_HI:INTR_TYPE_LO];
    assign drop_cnt     = drop_q;

`ifndef SYNTHESIS
    a_data_known: assert property (@(posedge clk) disable iff (!rst_n)
        noc_in_val |-> !$isunknown(noc_in_data));
`endif

endmodule

// File: tb/tb_noc_intr_pkt_decoder.sv
module tb_noc_intr_pkt_decoder;
    import noc_intr_pkt_decoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  my_x = 8'd0;
    logic [7:0]  my_y = 8'd0;
    logic        noc_in_val = 1'b0;
    logic        noc_in_rdy;
    logic [63:0] noc_in_data = '0;
    logic        intr_val;
    logic        intr_rdy = 1'b0;
    logic [63:0] intr_payload;
    logic [5:0]  intr_vec;
    logic [1:0]  intr_type;
    logic [15:0] drop_cnt;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned w;

    noc_intr_pkt_decoder #(
        .FIFO_DEPTH (4),
        .DROP_CNT_W (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .my_x         (my_x),
        .my_y         (my_y),
        .noc_in_val   (noc_in_val),
        .noc_in_rdy   (noc_in_rdy),
        .noc_in_data  (noc_in_data),
        .intr_val     (intr_val),
        .intr_rdy     (intr_rdy),
        .intr_payload (intr_payload),
        .intr_vec     (intr_vec),
        .intr_type    (intr_type),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] hdr(input logic [7:0] x, input logic [7:0] y,
                                        input logic [7:0] len, input logic [7:0] typ);
        logic [63:0] h;
        h = '0;
        h[49:42] = x;
        h[41:34] = y;
        h[29:22] = len;
        h[21:14] = typ;
        return h;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send(input logic [63:0] d, output int unsigned waits);
        noc_in_val  = 1'b1;
        noc_in_data = d;
        waits = 0;
        @(negedge clk);
        while (!noc_in_rdy && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!noc_in_rdy) check("send_timeout_rdy", noc_in_rdy, 1);
        @(posedge clk);
        #1;
        noc_in_val  = 1'b0;
        noc_in_data = '0;
    endtask

    task automatic pop1();
        intr_rdy = 1'b1;
        @(posedge clk);
        #1;
        intr_rdy = 1'b0;
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_intr_val", intr_val, 0);
        check("rst_noc_in_rdy", noc_in_rdy, 1);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_payload", intr_payload, 0);
        check("rst_vec", intr_vec, 0);
        check("rst_type", intr_type, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1) Good packet, latency and field decode
        send(hdr(8'd0, 8'd0, 8'd1, MSG_TYPE_INTERRUPT), w);
        check("t1_hdr_no_val", intr_val, 0);
        send(64'h0000_0000_0003_0025, w);
        check("t1_val", intr_val, 1);
        check("t1_vec", intr_vec, 6'h25);
        check("t1_type", intr_type, 2'b11);
        check("t1_payload", intr_payload, 64'h0000_0000_0003_0025);
        check("t1_drop", drop_cnt, 0);
        pop1();
        check("t1_popped", intr_val, 0);

        // 2) Wrong X -> drained and counted, then a good one
        send(hdr(8'd1, 8'd0, 8'd1, MSG_TYPE_INTERRUPT), w);
        send(64'h0000_0000_0003_0025, w);
        check("t2_no_val", intr_val, 0);
        check("t2_drop", drop_cnt, 1);
        send(hdr(8'd0, 8'd0, 8'd1, MSG_TYPE_INTERRUPT), w);
        send(64'h0000_0000_0001_000A, w);
        check("t2_good_val", intr_val, 1);
        check("t2_good_vec", intr_vec, 6'h0A);
        check("t2_good_type", intr_type, 2'b01);
        pop1();

        // 3) Non-interrupt len=3: four flits accepted without stall
        send(hdr(8'd0, 8'd0, 8'd3, 8'd1), w);
        check("t3_wait_hdr", w, 0);
        for (int i = 0; i < 3; i++) begin
            send(64'h0000_0000_0000_0030 + 64'(i), w);
            check("t3_wait_pay", w, 0);
        end
        check("t3_no_val", intr_val, 0);
        check("t3_drop", drop_cnt, 2);
        send(hdr(8'd0, 8'd0, 8'd1, MSG_TYPE_INTERRUPT), w);
        send(64'h0000_0000_0002_0007, w);
        check("t3_back_hdr_vec", intr_vec, 6'h07);
        pop1();
        check("t3_empty", intr_val, 0);

        // 4) Fill FIFO with intr_rdy low, fifth payload stalls until a pop
        for (int i = 1; i <= 4; i++) begin
            send(hdr(8'd0, 8'd0, 8'd1, MSG_TYPE_INTERRUPT), w);
            send(64'(i), w);
        end
        send(hdr(8'd0, 8'd0, 8'd1, MSG_TYPE_INTERRUPT), w);
        check("t4_hdr5_wait", w, 0);
        noc_in_val  = 1'b1;
        noc_in_data = 64'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_stall_rdy", noc_in_rdy, 0);
            check("t4_head_stable", intr_vec, 6'd1);
        end
        @(negedge clk);
        intr_rdy = 1'b1;
        check("t4_full_pop_rdy", noc_in_rdy, 0);
        @(posedge clk);
        #1;
        intr_rdy = 1'b0;
        @(negedge clk);
        check("t4_unstall_rdy", noc_in_rdy, 1);
        @(posedge clk);
        #1;
        noc_in_val  = 1'b0;
        noc_in_data = '0;
        for (int i = 2; i <= 5; i++) begin
            check("t4_order_val", intr_val, 1);
            check("t4_order_vec", intr_vec, 6'(i));
            pop1();
        end
        check("t4_drained", intr_val, 0);

        // 5) len=2 queues only first payload; len=0 interrupt is a drop
        send(hdr(8'd0, 8'd0, 8'd2, MSG_TYPE_INTERRUPT), w);
        send(64'h0000_0000_0000_002A, w);
        send(64'h0000_0000_0000_003F, w);
        check("t5_val", intr_val, 1);
        check("t5_vec", intr_vec, 6'h2A);
        pop1();
        check("t5_only_one", intr_val, 0);
        check("t5_drop_before", drop_cnt, 2);
        send(hdr(8'd0, 8'd0, 8'd0, MSG_TYPE_INTERRUPT), w);
        check("t5_len0_drop", drop_cnt, 3);
        check("t5_len0_no_val", intr_val, 0);
        check("t5_len0_rdy", noc_in_rdy, 1);

        // 6) Reset between header and payload, with a queued descriptor
        send(hdr(8'd0, 8'd0, 8'd1, MSG_TYPE_INTERRUPT), w);
        send(64'h0000_0000_0000_0011, w);
        send(hdr(8'd0, 8'd0, 8'd1, MSG_TYPE_INTERRUPT), w);
        check("t6_pre_val", intr_val, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_val", intr_val, 0);
        check("t6_rst_drop", drop_cnt, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(hdr(8'd0, 8'd0, 8'd1, MSG_TYPE_INTERRUPT), w);
        check("t6_hdr_no_val", intr_val, 0);
        send(64'h0000_0000_0000_0015, w);
        check("t6_val", intr_val, 1);
        check("t6_payload", intr_payload, 64'h0000_0000_0000_0015);
        pop1();
        check("t6_empty", intr_val, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
